stoch_bitstream_decoder: RTL
============================

Name: stoch_bitstream_decoder

Overview:
- Converts a unipolar stochastic bitstream back to a binary value. It counts the ones seen over a fixed window of 2^WIDTH valid bits.
- Receive-side counterpart to the stochastic number generator that feeds the add/multiply datapath.
- Sits between the stochastic arithmetic core and the uo_out output register.
- Presents each result on a valid/ready handshake.

Parameters:
- WIDTH, 8, result width; the window length is 2^WIDTH valid bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- start  input  1  single-cycle pulse that begins a new window.
- bit_in  input  1  stochastic stream bit.
- bit_valid  input  1  qualifies bit_in; sampled only in ACCUM.
- result  output  WIDTH  decoded value.
- result_valid  output  1  result available; held until accepted.
- result_ready  input  1  consumer accepts result when high with result_valid.
- busy  output  1  high in ACCUM.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, result=0, result_valid=0, busy=0, internal counters=0.
- Internal counters:
  - win_cnt: WIDTH+1 bits, counts valid bits in the current window.
  - ones_cnt: WIDTH+1 bits, counts ones.
- FSM states:
  - IDLE: start -> ACCUM, clearing win_cnt and ones_cnt. bit_valid is ignored.
  - ACCUM: on each bit_valid, win_cnt += 1 and ones_cnt += bit_in.
    - The cycle in which the 2^WIDTH-th valid bit is sampled moves to HOLD.
    - result is loaded with the final count (including that bit) and result_valid rises on the next edge. Latency from the last valid bit to result_valid is 1 cycle.
  - HOLD: result and result_valid are stable until result_valid && result_ready.
    - Handshake only -> IDLE, with result_valid low on the next edge.
    - Handshake and start in the same cycle -> ACCUM directly, with counters cleared.
- Start in ACCUM: restarts the window. Counters are cleared and the bit sampled that cycle is discarded.
- Start in HOLD without result_ready: ignored; a held result is never overwritten.
- result is unchanged outside HOLD entry; the last value is retained after handshake.
- Saturation: ones_cnt can equal 2^WIDTH (all ones). This is reported as 2^WIDTH-1, so result always fits in WIDTH bits.
- Reset mid-operation: asynchronous return to the reset values above. Any partial window is lost.
- No bit_valid for arbitrarily long: stays in ACCUM (no timeout).
- bit_in is treated as don't-care when bit_valid is low.

Optional Feature:
- Macro: STOCH_DEC_BIPOLAR_EN.
- Defined: result is bipolar two's complement, result = ones_cnt - 2^(WIDTH-1).
  - Range -2^(WIDTH-1) .. 2^(WIDTH-1)-1.
  - ones_cnt = 2^WIDTH saturates to 2^(WIDTH-1)-1.
- Undefined: unipolar result as above.
- The handshake and FSM are identical in both builds.

Decomposition:
- Shared package stoch_pkg:
  - state enum: IDLE, ACCUM, HOLD.
  - default WIDTH constant.
  - saturation helper function (count-to-result, both polarity variants).
- One natural sub-module: stoch_window_counter, holding win_cnt and ones_cnt with clear/enable and a window-done flag.
- The FSM and output register live in the top.

Test Plan:
All cases use WIDTH=4 (16-bit window).
- Reset, then start and 16 valid zeros -> result_valid one cycle after the 16th bit, result=0; hold result_ready low for 5 cycles -> result stays 0 and result_valid stays high.
- 16 valid ones -> result=15 (saturated); in the bipolar build result=7.
- Alternating 1,0 pattern with bit_valid low on every third cycle, 16 valid bits total -> result=8; bipolar build result=0; busy high throughout ACCUM.
- Start after 10 valid bits (6 ones), then 16 fresh bits with 4 ones -> result=4; earlier bits are discarded.
- In HOLD, start with result_ready low -> ignored, result unchanged; then start and result_ready together -> immediately ACCUM, busy=1, next window decodes independently.
- Assert rst asynchronously mid-window, between clock edges -> result=0, result_valid=0 and busy=0 before the next edge; after release, start and 16 ones -> 15.

Source files
------------

// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic bitstream decoder.
//   state_e         : decoder FSM states
//   DefaultWidth    : default result width (window = 2**width valid bits)
//   count_to_result : maps a window ones-count to the reported result, with
//                     saturation and optional bipolar offset
package stoch_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  // A full window of ones (count == 2**width) would need width+1 bits, so it
  // is clamped to the largest representable value before any offset.
  function automatic logic [31:0] count_to_result(input logic [31:0] cnt,
                                                  input int unsigned width,
                                                  input logic bipolar);
    logic [31:0] max_cnt;
    logic [31:0] sat;
    logic [31:0] res;
    max_cnt = (32'd1 << width) - 32'd1;
    sat     = (cnt > max_cnt) ? max_cnt : cnt;
    // Bipolar: two's complement of sat - 2**(width-1); caller keeps low bits.
    res     = bipolar ? (sat - (32'd1 << (width - 1))) : sat;
    return res;
  endfunction

endpackage

// File: rtl/stoch_window_counter.sv
// Window and ones counters for the stochastic decoder.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : clear both counters (wins over en)
//   en        : sample bit_in as a valid stream bit
//   bit_in    : stochastic stream bit
//   ones_next : ones count including the bit sampled this cycle
//   done      : this cycle samples the last valid bit of the window
module stoch_window_counter
  import stoch_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           bit_in,
  output logic [WIDTH:0] ones_next,
  output logic           done
);

  localparam logic [WIDTH:0] WinLast = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH:0] win_cnt_q;
  logic [WIDTH:0] ones_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q  <= '0;
      ones_cnt_q <= '0;
    end else if (clr) begin
      win_cnt_q  <= '0;
      ones_cnt_q <= '0;
    end else if (en) begin
      win_cnt_q  <= win_cnt_q + 1'b1;
      ones_cnt_q <= ones_next;
    end
  end

  always_comb begin
    ones_next = ones_cnt_q + {{WIDTH{1'b0}}, bit_in};
    done      = en && (win_cnt_q == WinLast);
  end

endmodule

// File: rtl/stoch_bitstream_decoder.sv
// Decodes a unipolar stochastic bitstream by counting ones over a window of
// 2**WIDTH valid bits; each result is offered on a valid/ready handshake.
// Build option: define STOCH_DEC_BIPOLAR_EN for a bipolar two's complement
// result (ones - 2**(WIDTH-1)); the FSM and handshake are unchanged.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : pulse that begins (or restarts) a window
//   bit_in       : stochastic stream bit, qualified by bit_valid
//   bit_valid    : bit_in is valid (only used while accumulating)
//   result       : decoded value, retained after acceptance
//   result_valid : result on offer, held until result_ready
//   result_ready : consumer accepts result
//   busy         : window accumulation in progress
module stoch_bitstream_decoder
  import stoch_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

`ifdef STOCH_DEC_BIPOLAR_EN
  localparam logic Bipolar = 1'b1;
`else
  localparam logic Bipolar = 1'b0;
`endif

  state_e         state_q, state_d;
  logic           clr, en, done, load;
  logic [WIDTH:0] ones_next;
  logic [WIDTH-1:0] result_q;

  stoch_window_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (en),
    .bit_in   (bit_in),
    .ones_next(ones_next),
    .done     (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StAccum;
      StAccum: if (!start && done) state_d = StHold;
      StHold:  if (result_ready) state_d = start ? StAccum : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (state_q == StAccum);
    result_valid = (state_q == StHold);
    en           = busy && bit_valid;
    // A start in HOLD only counts if it rides on the accepting handshake.
    clr          = start && ((state_q != StHold) || result_ready);
    // A start on the final bit restarts the window, so nothing is loaded.
    load         = busy && !start && done;
    result       = result_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if (load) begin
      result_q <= WIDTH'(count_to_result(32'(ones_next), WIDTH, Bipolar));
    end
  end

endmodule
